// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Pointer width carries one extra bit to tell full from empty.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer side bundle of the sync FIFO.
// master drives requests, slave is the FIFO itself.
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);

    localparam int CW = fifo_ptr_w(DEPTH);

    logic             wen;
    logic [WIDTH-1:0] din;
    logic             ren;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wen,
        output din,
        output ren,
        output clr_err,
        input  dout,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wen,
        input  din,
        input  ren,
        input  clr_err,
        output dout,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Enable-gated wrapping pointer for the FIFO read and write sides.
// Wraps naturally at 2^W.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with standard or first-word-fall-through read,
// fill count, programmable almost flags and sticky error flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 16,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic           clk,
    input  logic           reset,
    sync_fifo_ctrl_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = fifo_ptr_w(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic             overflow;
    logic             underflow;

    fifo_ptr #(.W(CW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(CW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (rd_en),
        .ptr   (rd_ptr)
    );

    // Flags depend on registered pointers only, never on wen/ren.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign wr_en = bus.wen && !full;
    assign rd_en = bus.ren && !empty;

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= CW'(AF_THRESH));
    assign bus.almost_empty = (count <= CW'(AE_THRESH));
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PW-1:0]] <= bus.din;
        end
    end

    // A new error in the same cycle as clr_err must not be lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wen && full) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end
            if (bus.ren && empty) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.dout = empty ? '0 : mem[rd_ptr[PW-1:0]];
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dout_q <= '0;
            end else if (rd_en) begin
                dout_q <= mem[rd_ptr[PW-1:0]];
            end
        end

        assign bus.dout = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl in standard and FWFT modes.
// Read data is checked by a monitor against a queue of expected words.
module tb_sync_fifo_ctrl;
    import fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] exp_q [$];
    logic        pend_s;

    sync_fifo_ctrl_if #(.WIDTH(16), .DEPTH(8)) bus_s ();
    sync_fifo_ctrl_if #(.WIDTH(16), .DEPTH(8)) bus_f ();

    sync_fifo_ctrl #(
        .DEPTH(8), .WIDTH(16), .FWFT(FIFO_MODE_STD),
        .AF_THRESH(6), .AE_THRESH(2)
    ) u_std (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_s)
    );

    sync_fifo_ctrl #(
        .DEPTH(8), .WIDTH(16), .FWFT(FIFO_MODE_FWFT),
        .AF_THRESH(6), .AE_THRESH(2)
    ) u_fw (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an accepted standard-mode read presents data after the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_s <= 1'b0;
        else        pend_s <= bus_s.ren && !bus_s.empty;
    end

    always @(negedge clk) begin
        if (pend_s) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data: got 0x%0h expected none (queue empty)",
                         bus_s.dout);
            end else begin
                check("rd_data", 32'(bus_s.dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_s.wen = 0; bus_s.ren = 0; bus_s.clr_err = 0; bus_s.din = '0;
        bus_f.wen = 0; bus_f.ren = 0; bus_f.clr_err = 0; bus_f.din = '0;
        #12;
        check("rst_count", 32'(bus_s.count), 0);
        check("rst_empty", 32'(bus_s.empty), 1);
        check("rst_aempty", 32'(bus_s.almost_empty), 1);
        check("rst_full", 32'(bus_s.full), 0);
        check("rst_dout", 32'(bus_s.dout), 0);
        check("rst_ovf", 32'(bus_s.overflow), 0);
        check("rst_unf", 32'(bus_s.underflow), 0);
        rst_n = 1'b1;
        tick();

        // Fill to full, watching the flag thresholds.
        for (int i = 0; i < 8; i++) begin
            bus_s.wen = 1;
            bus_s.din = 16'h1000 + 16'(i);
            exp_q.push_back(16'h1000 + 16'(i));
            tick();
            check("fill_count", 32'(bus_s.count), 32'(i + 1));
            check("fill_aempty", 32'(bus_s.almost_empty), 32'(i + 1 <= 2));
            check("fill_afull", 32'(bus_s.almost_full), 32'(i + 1 >= 6));
            check("fill_full", 32'(bus_s.full), 32'(i + 1 == 8));
        end
        bus_s.din = 16'hDEAD;
        tick();
        bus_s.wen = 0;
        check("ovf_count", 32'(bus_s.count), 8);
        check("ovf_flag", 32'(bus_s.overflow), 1);

        // Drain, then one read too many.
        bus_s.ren = 1;
        repeat (8) tick();
        check("drain_count", 32'(bus_s.count), 0);
        check("drain_empty", 32'(bus_s.empty), 1);
        tick();
        bus_s.ren = 0;
        check("unf_flag", 32'(bus_s.underflow), 1);
        check("unf_dout", 32'(bus_s.dout), 32'h1007);
        bus_s.clr_err = 1;
        tick();
        bus_s.clr_err = 0;
        check("clr_ovf", 32'(bus_s.overflow), 0);
        check("clr_unf", 32'(bus_s.underflow), 0);

        // Prime four words, then stream with read and write together.
        bus_s.wen = 1;
        for (int i = 0; i < 4; i++) begin
            bus_s.din = 16'h2000 + 16'(i);
            exp_q.push_back(16'h2000 + 16'(i));
            tick();
        end
        bus_s.ren = 1;
        for (int i = 4; i < 24; i++) begin
            bus_s.din = 16'h2000 + 16'(i);
            exp_q.push_back(16'h2000 + 16'(i));
            tick();
            check("stream_count", 32'(bus_s.count), 4);
        end
        bus_s.ren = 0;
        for (int i = 0; i < 4; i++) begin
            bus_s.din = 16'h3000 + 16'(i);
            exp_q.push_back(16'h3000 + 16'(i));
            tick();
        end
        check("refull", 32'(bus_s.full), 1);

        // Full with both requests: only the read goes through.
        bus_s.ren = 1;
        bus_s.din = 16'hBAD0;
        tick();
        bus_s.ren = 0;
        check("wr_rd_full_count", 32'(bus_s.count), 7);
        check("wr_rd_full_ovf", 32'(bus_s.overflow), 1);
        bus_s.din = 16'hC001;
        exp_q.push_back(16'hC001);
        tick();
        bus_s.din = 16'hBAD1;
        bus_s.clr_err = 1;
        tick();
        bus_s.wen = 0;
        check("set_wins_ovf", 32'(bus_s.overflow), 1);
        check("set_wins_count", 32'(bus_s.count), 8);
        tick();
        bus_s.clr_err = 0;
        check("clr_only_ovf", 32'(bus_s.overflow), 0);

        // Re-arm overflow, drain to five, then reset between edges.
        bus_s.wen = 1;
        bus_s.din = 16'hBAD2;
        tick();
        bus_s.wen = 0;
        bus_s.ren = 1;
        repeat (3) tick();
        bus_s.ren = 0;
        check("pre_rst_count", 32'(bus_s.count), 5);
        check("pre_rst_ovf", 32'(bus_s.overflow), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_count", 32'(bus_s.count), 0);
        check("async_empty", 32'(bus_s.empty), 1);
        check("async_ovf", 32'(bus_s.overflow), 0);
        check("async_dout", 32'(bus_s.dout), 0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        bus_s.wen = 1;
        bus_s.din = 16'hA5A5;
        exp_q.push_back(16'hA5A5);
        tick();
        bus_s.wen = 0;
        check("post_rst_addr0", 32'(u_std.mem[0]), 32'hA5A5);
        bus_s.ren = 1;
        tick();
        bus_s.ren = 0;
        tick();
        check("queue_drained", 32'(exp_q.size()), 0);

        // FWFT: head word visible right after its write edge.
        check("fw_rst_empty", 32'(bus_f.empty), 1);
        check("fw_rst_dout", 32'(bus_f.dout), 0);
        bus_f.wen = 1;
        bus_f.din = 16'hBEEF;
        tick();
        bus_f.wen = 0;
        check("fw_dout", 32'(bus_f.dout), 32'hBEEF);
        check("fw_empty", 32'(bus_f.empty), 0);
        bus_f.ren = 1;
        tick();
        bus_f.ren = 0;
        check("fw_pop_dout", 32'(bus_f.dout), 0);
        check("fw_pop_empty", 32'(bus_f.empty), 1);
        bus_f.wen = 1;
        bus_f.din = 16'h1111;
        tick();
        bus_f.din = 16'h2222;
        tick();
        bus_f.wen = 0;
        check("fw_head1", 32'(bus_f.dout), 32'h1111);
        bus_f.ren = 1;
        tick();
        bus_f.ren = 0;
        check("fw_head2", 32'(bus_f.dout), 32'h2222);
        check("fw_count", 32'(bus_f.count), 1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO; successor to the team's basic synchronous FIFO.
- Adds selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Adds a fill count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between producer/consumer pipeline stages in one clock domain.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- WIDTH, 16, data width in bits.
- FWFT, 0, 0 = standard mode (dout registered, valid the cycle after an accepted read); 1 = FWFT mode (head word presented on dout while not empty).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- Localparam PW = $clog2(DEPTH); pointers are PW+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wen  in  1  write request.
- din  in  WIDTH  write data.
- ren  in  1  read request (in FWFT mode, pops the head word).
- dout  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  PW+1  words stored, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (reset == 0, asynchronous):
  - Write pointer, read pointer, count, overflow, underflow and registered dout all go to 0.
  - After reset: empty = 1, almost_empty = 1, full = 0.
  - Takes effect immediately, including mid-transfer. Storage contents are not reset and are unobservable until written.
- Pointers and count:
  - count = wr_ptr - rd_ptr, modulo 2^(PW+1).
  - Storage is indexed by ptr[PW-1:0]; the MSB disambiguates full from empty, so all DEPTH locations are usable.
  - Pointers wrap naturally with no special case.
- Flags: full, empty, almost_full, almost_empty and count are combinational from the registered pointers only. No combinational path exists from wen/ren to any flag.
- Write: accepted iff wen && !full. On acceptance, din is stored at wr_ptr and wr_ptr increments at the clock edge.
- Read, standard mode (FWFT=0):
  - Accepted iff ren && !empty.
  - On acceptance, dout <= mem[rd_ptr] and rd_ptr increments (1-cycle latency).
  - dout holds its last value otherwise.
- Read, FWFT mode (FWFT=1):
  - dout = empty ? 0 : mem[rd_ptr[PW-1:0]], combinational from registers.
  - ren && !empty pops the head; the next word appears after the edge.
  - A word written into an empty FIFO at edge N is on dout, with empty = 0, in the cycle after edge N.
- Simultaneous wen && ren:
  - Not full and not empty: both accepted; count unchanged.
  - While empty: write accepted, read rejected, underflow set.
  - While full: read accepted, write rejected, overflow set. No same-cycle pass-through in either case.
- Error flags:
  - overflow sets on wen && full; underflow sets on ren && empty.
  - Both hold until clr_err. When set and clear occur in the same cycle, set wins.
- Rejected operations change no pointer, no storage and no dout.
- Elaboration checks: $error if DEPTH is not a power of two, DEPTH < 2, or either threshold is out of range.

Decomposition:
- Package fifo_pkg holds:
  - constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - function fifo_ptr_w(depth) returning $clog2(depth)+1, shared by all FIFO variants.
- One sub-module is natural: fifo_ptr, an enable-gated PW+1-bit wrapping counter with asynchronous active-low reset, instantiated once for write and once for read.
- Flag logic and storage stay in the top module.

Test Plan (DEPTH=8, WIDTH=16, AF_THRESH=6, AE_THRESH=2):
- Reset, then write 8 words 0x1000..0x1007 -> count increments 0->8; almost_empty drops when count reaches 3; almost_full rises when count reaches 6; full = 1 at count 8; 9th write is rejected and overflow = 1.
- From full, read 8 words (FWFT=0) -> dout = 0x1000..0x1007, each one cycle after its ren; empty = 1 afterwards; an extra ren sets underflow and leaves dout at 0x1007.
- FWFT=1, empty FIFO, write 0xBEEF at edge N -> dout = 0xBEEF with empty = 0 in cycle N+1; ren pops it; dout = 0 and empty = 1 after the edge.
- Stream 20 words with wen = ren = 1 continuously after 4 primed writes -> count stays 4; pointers wrap past 8 and 16 with no data loss or reorder.
- Full with wen && ren asserted -> read accepted, write rejected, overflow = 1, count = 7; then clr_err && wen while full -> overflow stays 1 (set wins).
- Assert reset mid-stream at count 5, asynchronously between edges -> count = 0, empty = 1 and the error flags clear immediately without waiting for a clock edge; the first write after release lands at address 0.
